mmio_periph_bus: RTL and testbench

Parametrised memory-mapped peripheral controller between the single-cycle CPU's data-memory port and board I/O. Decodes a 256-byte window at BASE_ADDR, suppresses data-memory writes that hit the window, and holds the peripheral registers: LED output, synchronised switch input, a latched input-data mailbox with a clear-on-read valid flag, and a controllable cycle counter. Read data is combinational, so the CPU's load/store timing is unchanged.

---
 rtl/mmio_pkg.sv | 25 ++
 rtl/mmio_cycle_counter.sv | 31 +++
 rtl/mmio_periph_bus.sv | 126 ++++++++++++
 tb/tb_mmio_periph_bus.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped peripheral block: word offsets, CTRL bits, default window.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_7F00;

  // Word offset inside the 256-byte window (addr[7:2])
  localparam int unsigned OFF_W = 6;
  typedef logic [OFF_W-1:0] off_t;

  localparam off_t OFF_LED      = 6'h00;  // byte 0x00
  localparam off_t OFF_SW       = 6'h01;  // byte 0x04
  localparam off_t OFF_IN_DATA  = 6'h02;  // byte 0x08
  localparam off_t OFF_IN_VALID = 6'h03;  // byte 0x0C
  localparam off_t OFF_COUNT    = 6'h08;  // byte 0x20
  localparam off_t OFF_CTRL     = 6'h09;  // byte 0x24

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;

  // Word offset of a full address
  function automatic off_t word_off(input logic [31:0] a);
    return a[7:2];
  endfunction

endpackage

// File: rtl/mmio_cycle_counter.sv
// Free-running cycle counter with clear, software load and enable (clear > load > increment).
module mmio_cycle_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count register; wraps naturally from all-ones to zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mmio_periph_bus.sv
// Memory-mapped peripheral window on the CPU data port: decode, LED/SW/mailbox/counter registers, read mux.
module mmio_periph_bus
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SW_W      = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_write_out,
  output logic             is_mmio,
  output logic [31:0]      rdata_mmio,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  sw,
  input  logic [31:0]      in_data,
  input  logic             in_valid
);

  logic             w_hit;
  off_t             w_off;
  logic             w_wr;
  logic             w_rd;
  logic             w_cnt_load;
  logic             w_cnt_clr;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_rdata;
  logic             w_unused_bits;

  logic [LED_W-1:0] r_led;
  logic [SW_W-1:0]  r_sw_s1;
  logic [SW_W-1:0]  r_sw_s2;
  logic [31:0]      r_in_data;
  logic             r_in_valid;
  logic             r_enable;

  // Window decode; byte lane bits are ignored
  assign w_hit = (addr[31:8] == BASE_ADDR[31:8]);
  assign w_off = word_off(addr);
  assign w_wr  = w_hit & mem_write;
  assign w_rd  = w_hit & mem_read;

  assign is_mmio       = w_hit;
  assign mem_write_out = mem_write & ~w_hit;

  assign w_cnt_load = w_wr & (w_off == OFF_COUNT);
  assign w_cnt_clr  = w_wr & (w_off == OFF_CTRL) & wdata[CTRL_CLR_BIT];

  assign w_unused_bits = &{1'b0, addr[1:0], wdata};

  // LED register and CTRL.enable, software writable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_led    <= '0;
      r_enable <= 1'b1;
    end else begin
      if (w_wr && (w_off == OFF_LED)) begin
        r_led <= wdata[LED_W-1:0];
      end
      if (w_wr && (w_off == OFF_CTRL)) begin
        r_enable <= wdata[CTRL_EN_BIT];
      end
    end
  end

  // Two-flop synchroniser for the asynchronous board switches
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // Mailbox: a new strobe wins over the clear-on-read of IN_DATA
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
    end else if (in_valid) begin
      r_in_data  <= in_data;
      r_in_valid <= 1'b1;
    end else if (w_rd && (w_off == OFF_IN_DATA)) begin
      r_in_valid <= 1'b0;
    end
  end

  mmio_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk       (clk),
    .rstn      (rstn),
    .i_en      (r_enable),
    .i_clr     (w_cnt_clr),
    .i_load    (w_cnt_load),
    .i_load_val(wdata[CNT_W-1:0]),
    .o_count   (w_count)
  );

  // Combinational read mux; zero outside a window load
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_off)
        OFF_LED:      w_rdata = 32'(r_led);
        OFF_SW:       w_rdata = 32'(r_sw_s2);
        OFF_IN_DATA:  w_rdata = r_in_data;
        OFF_IN_VALID: w_rdata = 32'(r_in_valid);
        OFF_COUNT:    w_rdata = 32'(w_count);
        OFF_CTRL:     w_rdata = 32'(r_enable);
        default:      w_rdata = '0;
      endcase
    end
  end

  assign rdata_mmio = w_rdata;
  assign led        = r_led;

endmodule

// File: tb/tb_mmio_periph_bus.sv
// Self-checking bench for mmio_periph_bus: hand sequences for counter/reset, table of bus vectors.
module tb_mmio_periph_bus;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        mem_write_out;
  logic        is_mmio;
  logic [31:0] rdata_mmio;
  logic [15:0] led;
  logic [15:0] sw;
  logic [31:0] in_data;
  logic        in_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mmio_periph_bus dut (
    .clk          (clk),
    .rstn         (rstn),
    .addr         (addr),
    .wdata        (wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_write_out(mem_write_out),
    .is_mmio      (is_mmio),
    .rdata_mmio   (rdata_mmio),
    .led          (led),
    .sw           (sw),
    .in_data      (in_data),
    .in_valid     (in_valid)
  );

  typedef struct {
    string       nm;
    logic [31:0] exp_rd;
    logic        exp_is;
    logic        exp_mwo;
    logic        chk_led;
    logic [15:0] exp_led;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic        iv;
    logic [31:0] din;
    logic [15:0] swv;
    logic [31:0] exp_rd;
    logic        exp_is;
    logic        exp_mwo;
    logic [15:0] exp_led;
  } vec_t;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Pop one expectation and compare against the current DUT outputs
  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    cmp({e.nm, ".rdata"}, rdata_mmio, e.exp_rd);
    cmp({e.nm, ".is_mmio"}, 32'(is_mmio), 32'(e.exp_is));
    cmp({e.nm, ".mwo"}, 32'(mem_write_out), 32'(e.exp_mwo));
    if (e.chk_led) cmp({e.nm, ".led"}, 32'(led), 32'(e.exp_led));
  endtask

  // One bus cycle: drive after the edge, check mid-cycle, advance past the next edge
  task automatic step(input string nm, input logic [31:0] a, input logic [31:0] wd,
                      input logic rd, input logic wr, input logic [31:0] exp_rd,
                      input logic exp_is, input logic exp_mwo,
                      input logic chk_led, input logic [15:0] exp_led);
    exp_t e;
    addr      = a;
    wdata     = wd;
    mem_read  = rd;
    mem_write = wr;
    e.nm = nm; e.exp_rd = exp_rd; e.exp_is = exp_is; e.exp_mwo = exp_mwo;
    e.chk_led = chk_led; e.exp_led = exp_led;
    sb.push_back(e);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    step(nm, a, 32'h0, 1'b1, 1'b0, exp, (a[31:8] == 24'h00007F), 1'b0, 1'b0, 16'h0);
  endtask

  task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] d);
    step(nm, a, d, 1'b0, 1'b1, 32'h0, (a[31:8] == 24'h00007F),
         (a[31:8] != 24'h00007F), 1'b0, 16'h0);
  endtask

  vec_t tbl[$];

  initial begin
    rstn = 1'b0; addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    sw = '0; in_data = '0; in_valid = 1'b0;

    // Reset state
    @(posedge clk); #1;
    rd("rst_ctrl", 32'h7F24, 32'h1);
    rd("rst_count", 32'h7F20, 32'h0);
    rd("rst_inval", 32'h7F0C, 32'h0);
    step("rst_led_mwo", 32'h1000, 32'h5, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 16'h0);

    // Release: cycles 0..4 idle, counter read in cycle 5
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("idle%0d", i), 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    end
    rd("cnt_cycle5", 32'h7F20, 32'd5);
    rd("ctrl_en", 32'h7F24, 32'h1);

    // Software load beats increment, then wrap
    wr("cnt_load", 32'h7F20, 32'hFFFF_FFFE);
    rd("cnt_fffe", 32'h7F20, 32'hFFFF_FFFE);
    rd("cnt_ffff", 32'h7F20, 32'hFFFF_FFFF);
    rd("cnt_wrap", 32'h7F20, 32'h0);

    // Clear + disable, then enable, then disable
    wr("ctrl_clr", 32'h7F24, 32'h2);
    rd("cnt_cleared", 32'h7F20, 32'h0);
    rd("ctrl_reads0", 32'h7F24, 32'h0);
    rd("cnt_frozen0", 32'h7F20, 32'h0);
    wr("ctrl_en1", 32'h7F24, 32'h1);
    rd("cnt_after_en", 32'h7F20, 32'h0);
    rd("cnt_run1", 32'h7F20, 32'h1);
    wr("ctrl_dis", 32'h7F24, 32'h0);
    rd("cnt_frz3a", 32'h7F20, 32'h3);
    rd("cnt_frz3b", 32'h7F20, 32'h3);

    // Vector table: {addr, wdata, rd, wr, in_valid, in_data, sw, rdata, is_mmio, mwo, led}
    tbl.push_back('{32'h7F00, 32'h0000_A5A5, 0, 1, 0, 32'h0,         16'h0,    32'h0,         1, 0, 16'h0});
    tbl.push_back('{32'h1000, 32'h0000_1234, 0, 1, 0, 32'h0,         16'h0,    32'h0,         0, 1, 16'hA5A5});
    tbl.push_back('{32'h7F00, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h0000_A5A5, 1, 0, 16'hA5A5});
    tbl.push_back('{32'h1000, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h0,         0, 0, 16'hA5A5});
    tbl.push_back('{32'h7F0C, 32'h0,         1, 0, 1, 32'hDEAD_BEEF, 16'h0,    32'h0,         1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F0C, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h1,         1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F08, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'hDEAD_BEEF, 1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F0C, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h0,         1, 0, 16'hA5A5});
    tbl.push_back('{32'h0,    32'h0,         0, 0, 1, 32'h1111_2222, 16'h0,    32'h0,         0, 0, 16'hA5A5});
    tbl.push_back('{32'h7F08, 32'h0,         1, 0, 1, 32'h3333_4444, 16'h0,    32'h1111_2222, 1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F0C, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h1,         1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F08, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h3333_4444, 1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F0C, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h0,         1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F40, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h0,         1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F40, 32'hFFFF_FFFF, 0, 1, 0, 32'h0,         16'h0,    32'h0,         1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F00, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h0000_A5A5, 1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F08, 32'h0000_0005, 0, 1, 0, 32'h0,         16'h0,    32'h0,         1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F08, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h3333_4444, 1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F20, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h3,         1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F03, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h0000_A5A5, 1, 0, 16'hA5A5});
    tbl.push_back('{32'h8F00, 32'h0,         1, 0, 0, 32'h0,         16'h0,    32'h0,         0, 0, 16'hA5A5});
    tbl.push_back('{32'h7F04, 32'h0,         1, 0, 0, 32'h0,         16'h1234, 32'h0,         1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F04, 32'h0,         1, 0, 0, 32'h0,         16'h1234, 32'h0,         1, 0, 16'hA5A5});
    tbl.push_back('{32'h7F04, 32'h0,         1, 0, 0, 32'h0,         16'h1234, 32'h0000_1234, 1, 0, 16'hA5A5});

    foreach (tbl[i]) begin
      sw       = tbl[i].swv;
      in_valid = tbl[i].iv;
      in_data  = tbl[i].din;
      step($sformatf("vec%0d", i), tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].wr,
           tbl[i].exp_rd, tbl[i].exp_is, tbl[i].exp_mwo, 1'b1, tbl[i].exp_led);
    end

    // Mid-cycle reset with LED set and counter running
    wr("ctrl_run", 32'h7F24, 32'h1);
    wr("led_ffff", 32'h7F00, 32'h0000_FFFF);
    step("led_is_ffff", 32'h7F00, 32'h0, 1'b1, 1'b0, 32'h0000_FFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    addr = 32'h7F20; mem_read = 1'b1;
    #2 rstn = 1'b0;
    #1;
    cmp("arst_led", 32'(led), 32'h0);
    cmp("arst_count", rdata_mmio, 32'h0);
    addr = 32'h7F24;
    #1;
    cmp("arst_ctrl_en", rdata_mmio, 32'h1);
    @(posedge clk); #1;
    step("rst_wr_abort", 32'h7F00, 32'h0000_00FF, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0);
    rstn = 1'b1;
    rd("post_rst_cnt", 32'h7F20, 32'h0);
    step("post_rst_led", 32'h7F00, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
